// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word plus the instruction cache address
// split, frame layout and controller states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic {
        IDLE,
        FETCH
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with combinational hit
// path, single-word miss fill, flush and saturating hit/miss counters.
module icache
    import cpu_types_pkg::*;
#(
    parameter  int SETS  = 16,
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    input  logic  flush,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload,
    output word_t hit_cnt,
    output word_t miss_cnt
);

    icache_state_t    state, state_next;
    word_t            fill_addr;
    logic             flush_seen;
    logic             start_miss;
    logic             fill;
    logic             hit_raw;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    word_t            frame_data [SETS];

    logic [TAG_W-1:0] req_tag, fill_tag;
    logic [IDX_W-1:0] req_idx, fill_idx;
    logic             unused_bits;

    assign req_tag     = imemaddr[31:IDX_W+2];
    assign req_idx     = imemaddr[IDX_W+1:2];
    assign fill_tag    = fill_addr[31:IDX_W+2];
    assign fill_idx    = fill_addr[IDX_W+1:2];
    assign unused_bits = ^imemaddr[1:0];

    // valid gates the compare so never-written (unreset) tags cannot produce a hit
    assign hit_raw = imemREN & valid[req_idx] & (tags[req_idx] == req_tag);

    always_comb begin
        state_next = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        start_miss = 1'b0;
        fill       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!flush && hit_raw) begin
                    ihit     = 1'b1;
                    imemload = frame_data[req_idx];
                end else if (!flush && imemREN) begin
                    start_miss = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = fill_addr;
                if (!iwait) begin
                    fill       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            fill_addr  <= '0;
            flush_seen <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            state <= state_next;
            if (start_miss) begin
                fill_addr <= {imemaddr[31:2], 2'b00};
            end
            if (fill) begin
                flush_seen <= 1'b0;
            end else if (state == FETCH && flush) begin
                flush_seen <= 1'b1;
            end
            if (ihit && hit_cnt != '1) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (start_miss && miss_cnt != '1) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    // Flush has priority over a same-cycle fill, leaving the filled frame invalid
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (fill) begin
            valid[fill_idx] <= !flush_seen;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill) begin
            tags[fill_idx]       <= fill_tag;
            frame_data[fill_idx] <= iload;
        end
    end

endmodule
